// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer for the multicycle RV32 core.
// Owns the program counter, issues req/ack reads to instruction memory,
// presents one instruction at a time to decode and applies redirects and
// trap vectoring, including while a read is still outstanding.
module fetch_ctrl #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_VEC = 'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_VEC  = 'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,        // asynchronous, active-low
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target;
  logic            take;

  // Redirect target: trap wins over a branch/jump; targets are word aligned.
  always_comb begin
    take   = trap | redirect;
    target = {redirect_pc[XLEN-1:2], 2'b00};
    if (trap) begin
      target = TRAP_VEC;
    end
  end

  // A read is outstanding exactly while in FETCH or DRAIN.
  assign imem_req = (state == FETCH) || (state == DRAIN);

  // Fetch sequencer: state, program counter, request address and the
  // presented instruction all update together on the rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_VEC;
      imem_addr   <= RESET_VEC;
      instr_valid <= 1'b0;
      instr       <= NOP;
      pc          <= RESET_VEC;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          if (take) begin
            fetch_pc  <= target;
            imem_addr <= target;
          end else begin
            imem_addr <= fetch_pc;
          end
        end

        FETCH: begin
          if (take) begin
            // Returned data (if any) belongs to the old stream and is dropped.
            fetch_pc    <= target;
            instr_valid <= 1'b0;
            if (imem_ack) begin
              imem_addr <= target;
              state     <= FETCH;
            end else begin
              // Memory still owes us a word; keep the old request up until ack.
              state <= DRAIN;
            end
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            pc          <= imem_addr;
            fetch_pc    <= imem_addr + XLEN'(4);
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end

        HOLD: begin
          if (take) begin
            // The held instruction is dropped even if decode is stalled.
            fetch_pc    <= target;
            imem_addr   <= target;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            imem_addr   <= fetch_pc;
            state       <= FETCH;
          end
        end

        DRAIN: begin
          if (take) begin
            fetch_pc <= target;
          end
          if (imem_ack) begin
            // Stale data is discarded; restart at the most recent target.
            imem_addr <= take ? target : fetch_pc;
            state     <= FETCH;
          end
        end

        default: begin
          state       <= BOOT;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus for fetch_ctrl with a scoreboard of
// expected memory requests and expected presented instructions.
module tb_fetch_ctrl;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;

  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_ins[$];

  fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .trap       (trap),
    .instr_valid(instr_valid),
    .instr      (instr),
    .pc         (pc)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    exp_req.push_back(a);
    exp_pc.push_back(a);
    exp_ins.push_back(a ^ K);
  endtask

  task automatic wait_valid(input logic [31:0] a);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (instr_valid && pc == a) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_valid: got no valid instr expected pc %h", a);
    end
  endtask

  // Memory model: ack after 'lat' request cycles, rdata = addr ^ K.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        imem_ack = 1'b0;
        cnt = 0;
      end else if (imem_req) begin
        if (cnt + 1 >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ K;
          cnt = 0;
        end else begin
          imem_ack = 1'b0;
          cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: compares completed requests and newly presented instructions.
  initial begin
    logic pv = 1'b0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (imem_req && imem_ack) begin
        if (exp_req.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL req_unexpected: got addr %h expected none", imem_addr);
        end else begin
          e = exp_req.pop_front();
          check("req_addr", imem_addr, e);
        end
      end
      if (instr_valid && !pv) begin
        if (exp_pc.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL instr_unexpected: got pc %h expected none", pc);
        end else begin
          e = exp_pc.pop_front();
          check("instr_pc", pc, e);
          e = exp_ins.pop_front();
          check("instr_word", instr, e);
        end
      end
      pv = instr_valid;
    end
  end

  initial begin
    logic [31:0] held;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", pc, 32'h0);

    // Sequential fetch, single-cycle ack
    for (int i = 0; i < 5; i++) push_fetch(32'(i * 4));
    reset = 1'b1;
    wait_valid(32'h8);
    @(negedge clk);
    stall = 1'b1;

    // Stall hold on pc 12
    wait_valid(32'hC);
    held = instr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_pc", pc, 32'hC);
      check("stall_instr", instr, held);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    wait_valid(32'h10);

    // Redirect while a 4-cycle read is outstanding
    lat = 4;
    exp_req.push_back(32'h14);
    push_fetch(32'h200);
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0203;
    stall = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    check("drain_req", {31'b0, imem_req}, 32'd1);
    check("drain_addr", imem_addr, 32'h14);
    check("drain_valid", {31'b0, instr_valid}, 32'd0);
    wait_valid(32'h200);

    // Trap and redirect together during HOLD
    push_fetch(32'h100);
    trap = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    trap = 1'b0;
    redirect = 1'b0;
    check("trap_valid", {31'b0, instr_valid}, 32'd0);
    check("trap_addr", imem_addr, 32'h100);
    wait_valid(32'h100);

    // Wrap at the top of the address space
    push_fetch(32'hFFFF_FFFC);
    push_fetch(32'h0);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    stall = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid(32'hFFFF_FFFC);
    @(negedge clk);
    stall = 1'b1;
    wait_valid(32'h0);

    // Asynchronous reset in the middle of DRAIN
    stall = 1'b0;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    stall = 1'b1;
    check("pre_rst_req", {31'b0, imem_req}, 32'd1);
    check("pre_rst_addr", imem_addr, 32'h4);
    #2;
    reset = 1'b0;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_valid", {31'b0, instr_valid}, 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_instr", instr, 32'h0000_0013);
    @(negedge clk);
    @(negedge clk);
    push_fetch(32'h0);
    reset = 1'b1;
    #1;
    check("boot_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    check("boot_next_req", {31'b0, imem_req}, 32'd1);
    check("boot_next_addr", imem_addr, 32'h0);
    wait_valid(32'h0);
    #5;
    check("req_queue_left", 32'(exp_req.size()), 32'd0);
    check("instr_queue_left", 32'(exp_pc.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
